instruction_fetch: RTL and testbench

Instruction-fetch stage of the five-stage DLX pipeline. Owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register that feeds `instruction_decode` with `nextPC` and the instruction word. It supports:
- hazard stalls;
- control-transfer redirects (which flush the fetched word);
- instruction-memory wait states (which insert a bubble).

---
 rtl/instruction_fetch.sv | 91 +++++++++
 tb/tb_instruction_fetch.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : DLX IF stage. Owns the PC and loads the IF/ID register.
// Revision    : 1.0
// ============================================================================
module instruction_fetch #(
    parameter int              SIZE     = 32,
    parameter logic [SIZE-1:0] RESET_PC = 32'h00000000,
    parameter logic [SIZE-1:0] NOP      = 32'h54000000
) (
    input  logic            clk,
    input  logic            reset,
    output logic [SIZE-1:0] imemAddr,
    input  logic [SIZE-1:0] imemData,
    input  logic            imemReady,
    input  logic            stall,
    input  logic            redirect,
    input  logic [SIZE-1:0] redirectPC,
    output logic [SIZE-1:0] nextPC_out,
    output logic [SIZE-1:0] instruction_out,
    output logic            valid_out,
    output logic [SIZE-1:0] fetchCount
);

    localparam logic [SIZE-1:0] c_pc_step   = SIZE'(4);
    localparam logic [SIZE-1:0] c_word_mask = ~SIZE'(3);
    localparam logic [SIZE-1:0] c_one       = SIZE'(1);
    localparam logic [SIZE-1:0] c_zero      = '0;

    logic [SIZE-1:0] r_pc_q,    w_pc_d;
    logic [SIZE-1:0] r_instr_q, w_instr_d;
    logic [SIZE-1:0] r_npc_q,   w_npc_d;
    logic            r_valid_q, w_valid_d;
    logic [SIZE-1:0] r_count_q, w_count_d;
    logic [SIZE-1:0] w_pc_plus4;

    // Wraps naturally modulo 2^SIZE.
    assign w_pc_plus4 = r_pc_q + c_pc_step;

    always_comb begin
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        w_npc_d   = r_npc_q;
        w_valid_d = r_valid_q;
        w_count_d = r_count_q;
        if (redirect) begin
            // Redirect wins over stall: IF/ID is flushed even if the hazard unit asked to hold it.
            w_pc_d    = redirectPC & c_word_mask;
            w_instr_d = NOP;
            w_npc_d   = c_zero;
            w_valid_d = 1'b0;
        end else if (stall) begin
            w_pc_d = r_pc_q;
        end else if (imemReady) begin
            w_pc_d    = w_pc_plus4;
            w_instr_d = imemData;
            w_npc_d   = w_pc_plus4;
            w_valid_d = 1'b1;
            w_count_d = r_count_q + c_one;
        end else begin
            w_instr_d = NOP;
            w_npc_d   = c_zero;
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_q    <= RESET_PC & c_word_mask;
            r_instr_q <= NOP;
            r_npc_q   <= c_zero;
            r_valid_q <= 1'b0;
            r_count_q <= c_zero;
        end else begin
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
            r_npc_q   <= w_npc_d;
            r_valid_q <= w_valid_d;
            r_count_q <= w_count_d;
        end
    end

    assign imemAddr        = r_pc_q;
    assign instruction_out = r_instr_q;
    assign nextPC_out      = r_npc_q;
    assign valid_out       = r_valid_q;
    assign fetchCount      = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed-vector scoreboard bench for instruction_fetch.
// Revision    : 1.0
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] c_nop = 32'h54000000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic        imemReady;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPC;
    logic [31:0] nextPC_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic [31:0] fetchCount;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    instruction_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .imemAddr        (imemAddr),
        .imemData        (imemData),
        .imemReady       (imemReady),
        .stall           (stall),
        .redirect        (redirect),
        .redirectPC      (redirectPC),
        .nextPC_out      (nextPC_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out),
        .fetchCount      (fetchCount)
    );

    always #5 clk = ~clk;

    // Instruction memory model: word at address A is A + 0x100.
    assign imemData = imemAddr + 32'h100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] i, input logic [31:0] n,
                            input logic v, input logic [31:0] c);
        exp_t e;
        e.addr = a; e.instr = i; e.npc = n; e.valid = v; e.cnt = c;
        exp_q.push_back(e);
    endtask

    // One clock edge: drive inputs at the falling edge, record the state expected after the next rising edge.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy,
                        input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] en,
                        input logic ev, input logic [31:0] ec);
        @(negedge clk);
        reset      = 1'b1;
        stall      = st;
        redirect   = rd;
        redirectPC = rpc;
        imemReady  = rdy;
        push_exp(ea, ei, en, ev, ec);
        @(posedge clk);
    endtask

    // Monitor: the DUT presents new outputs after each rising clock edge or reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imemAddr",        imemAddr,         e.addr);
                chk("instruction_out", instruction_out,  e.instr);
                chk("nextPC_out",      nextPC_out,       e.npc);
                chk("valid_out",       {31'b0, valid_out}, {31'b0, e.valid});
                chk("fetchCount",      fetchCount,       e.cnt);
            end
        end
    end

    initial begin
        reset      = 1'b0;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPC = 32'h0;
        imemReady  = 1'b1;

        // Reset state observed with clock running.
        @(negedge clk);
        push_exp(32'h0, c_nop, 32'h0, 1'b0, 32'd0);
        @(posedge clk);

        // Straight-line fetch.
        step(0, 0, 32'h0, 1, 32'h4,  32'h100, 32'h4,  1, 32'd1);
        step(0, 0, 32'h0, 1, 32'h8,  32'h104, 32'h8,  1, 32'd2);
        // Stall at PC=8 for three cycles.
        step(1, 0, 32'h0, 1, 32'h8,  32'h104, 32'h8,  1, 32'd2);
        step(1, 0, 32'h0, 1, 32'h8,  32'h104, 32'h8,  1, 32'd2);
        step(1, 0, 32'h0, 1, 32'h8,  32'h104, 32'h8,  1, 32'd2);
        step(0, 0, 32'h0, 1, 32'hC,  32'h108, 32'hC,  1, 32'd3);
        // Redirect with simultaneous stall; low bits of target dropped.
        step(1, 1, 32'h43, 1, 32'h40, c_nop,  32'h0,  0, 32'd3);
        step(0, 0, 32'h0, 1, 32'h44, 32'h140, 32'h44, 1, 32'd4);
        // Move to PC=10, then two wait states.
        step(0, 1, 32'h10, 1, 32'h10, c_nop,  32'h0,  0, 32'd4);
        step(0, 0, 32'h0, 0, 32'h10, c_nop,   32'h0,  0, 32'd4);
        step(0, 0, 32'h0, 0, 32'h10, c_nop,   32'h0,  0, 32'd4);
        step(0, 0, 32'h0, 1, 32'h14, 32'h110, 32'h14, 1, 32'd5);
        // Stall during a wait state holds the valid instruction.
        step(1, 0, 32'h0, 0, 32'h14, 32'h110, 32'h14, 1, 32'd5);
        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFFFFFF, 0, 32'hFFFFFFFC, c_nop, 32'h0, 0, 32'd5);
        step(0, 0, 32'h0, 1, 32'h0,  32'hFC,  32'h0,  1, 32'd6);
        step(0, 0, 32'h0, 1, 32'h4,  32'h100, 32'h4,  1, 32'd7);

        // Asynchronous reset mid-cycle, then held across an edge.
        @(negedge clk);
        #2;
        push_exp(32'h0, c_nop, 32'h0, 1'b0, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        push_exp(32'h0, c_nop, 32'h0, 1'b0, 32'd0);
        @(posedge clk);
        // First fetch after reset comes from RESET_PC.
        step(0, 0, 32'h0, 1, 32'h4,  32'h100, 32'h4,  1, 32'd1);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
